tv_vram_arbiter: RTL and testbench
==================================

TV_VRAM_ARBITER -- requirements
Module: tv_vram_arbiter

Interface
REQ-001 The block SHALL have parameter VID_BASE, default 16'h4000: VRAM byte address of the first video byte.
REQ-002 The block SHALL have parameter H_START, default 88: cntHS value of the first video fetch on a line.
REQ-003 The block SHALL have parameter V_START, default 56: cntVS value of the first active line.
REQ-004 Ports SHALL be:
- clk_in  in  1: sole clock.
- rst  in  1: synchronous reset, active-low.
- pixel_clk  in  1: 1-cycle pixel strobe, clk_in domain.
- cntHS  in  9: horizontal counter.
- cntVS  in  9: vertical counter.
- vbl  in  1: vertical blanking flag.
- cpu_req  in  1: CPU access request.
- cpu_we  in  1: 1 = write.
- cpu_addr  in  16: CPU address.
- cpu_wdata  in  8: CPU write data.
- cpu_rdata  out  8: CPU read data.
- cpu_ack  out  1: access-complete pulse.
- mem_addr  out  16: VRAM address.
- mem_wdata  out  8: VRAM write data.
- mem_we  out  1: VRAM write enable.
- mem_ce  out  1: VRAM chip enable.
- mem_rdata  in  8: VRAM read data, valid one clk_in after mem_ce.
- vid_data  out  8: fetched video byte.
- vid_valid  out  1: vid_data-updated pulse.

Function
REQ-005 Fetch window: pixel_clk=1, cntHS[2:0]=0, H_START<=cntHS<H_START+256, V_START<=cntVS<V_START+192.
REQ-006 Video address SHALL be VID_BASE + {(cntVS-V_START)[7:0], ((cntHS-H_START)>>3)[4:0]}, 16-bit wrap, latched with the request.
REQ-007 A fetch-window strobe SHALL set vid_pend; vid_pend clears when the VID state is entered.
REQ-008 FSM states: IDLE, VID, VID_CAP, CPU, CPU_CAP.
REQ-009 IDLE: vid_pend -> VID; else cpu_req eligible -> CPU; else IDLE.
REQ-010 VID: mem_ce=1, mem_we=0, mem_addr=video address; next VID_CAP.
REQ-011 VID_CAP: vid_data<=mem_rdata, vid_valid=1 for one cycle; next IDLE.
REQ-012 CPU: mem_ce=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata; next CPU_CAP.
REQ-013 CPU_CAP: cpu_ack=1 for one cycle; on read, cpu_rdata<=mem_rdata; cpu_rdata holds otherwise; next IDLE.
REQ-014 cpu_req is ineligible in the cycle after cpu_ack; the CPU holds address, data and we stable from req until ack.
REQ-015 A simultaneous video strobe and cpu_req SHALL grant video first; the CPU is served next.
REQ-016 A video strobe during a CPU access SHALL pend and issue within 2 clk_in cycles; no fetch is lost.
REQ-017 mem_ce, mem_we, cpu_ack and vid_valid SHALL be 0 outside the states above.

Reset
REQ-018 With rst=0 at a clk_in edge: state=IDLE, vid_pend=0, all outputs 0.
REQ-019 Reset mid-access SHALL abort it with no cpu_ack or vid_valid; the CPU re-requests.

Configuration
REQ-020 VRAM_VBL_ONLY_EN defined: cpu_req is eligible only while vbl=1. Undefined: cpu_req is eligible whenever REQ-014 allows.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- cntVS=56, cntHS=88 strobe, mem_rdata=8'hA5 -> mem_addr=16'h4000 read; vid_data=8'hA5 with vid_valid 2 cycles after strobe.
- cntVS=57, cntHS=96 strobe -> mem_addr=16'h4021.
- cpu_req write 16'h1234<=8'h5A, idle -> mem_we=1 and mem_addr=16'h1234 next cycle; cpu_ack 2 cycles after req.
- cpu_req and video strobe in the same cycle -> VID first; CPU mem_ce 2 cycles later; both complete.
- VRAM_VBL_ONLY_EN, vbl=0, cpu_req held -> no cpu_ack until vbl=1.
- rst=0 during CPU state -> no cpu_ack; all outputs 0 next cycle.

Source files
------------

// File: rtl/tv_vram_arbiter.sv
// tv_vram_arbiter: shares a single-port VRAM between the raster video fetch
// and CPU accesses. Video fetches win over the CPU in any given cycle.
// Build option: define VRAM_VBL_ONLY_EN to restrict CPU accesses to vertical
// blanking (vbl=1).
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no access in flight, arbitrating
// VID     | video read issued to VRAM
// VID_CAP | video byte returned, vid_valid pulse
// CPU     | CPU read/write issued to VRAM
// CPU_CAP | CPU access complete, cpu_ack pulse
module tv_vram_arbiter #(
  parameter logic [15:0] VID_BASE = 16'h4000,
  parameter int          H_START  = 88,
  parameter int          V_START  = 56
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        pixel_clk,
  input  logic [8:0]  cntHS,
  input  logic [8:0]  cntVS,
  input  logic        vbl,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_ce,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  vid_data,
  output logic        vid_valid
);

`ifdef VRAM_VBL_ONLY_EN
  localparam bit VBL_ONLY = 1'b1;
`else
  localparam bit VBL_ONLY = 1'b0;
`endif

  localparam logic [9:0] H_LO = 10'(H_START);
  localparam logic [9:0] H_HI = 10'(H_START + 256);
  localparam logic [9:0] V_LO = 10'(V_START);
  localparam logic [9:0] V_HI = 10'(V_START + 192);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VID,
    ST_VID_CAP,
    ST_CPU,
    ST_CPU_CAP
  } state_t;

  state_t      state_q, state_d;
  logic        vid_pend_q, vid_pend_d;
  logic [15:0] vaddr_q, vaddr_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        ack_q, ack_d;

  logic        vid_strobe;
  logic        vid_go;
  logic        cpu_elig;
  logic [8:0]  hs_off;
  logic [8:0]  vs_off;
  logic [15:0] vaddr_calc;

  // Raster fetch-window detection and video address generation
  always_comb begin
    hs_off     = cntHS - 9'(H_START);
    vs_off     = cntVS - 9'(V_START);
    vaddr_calc = VID_BASE + {3'b000, vs_off[7:0], hs_off[7:3]};
    vid_strobe = pixel_clk && (cntHS[2:0] == 3'd0)
                 && ({1'b0, cntHS} >= H_LO) && ({1'b0, cntHS} < H_HI)
                 && ({1'b0, cntVS} >= V_LO) && ({1'b0, cntVS} < V_HI);
    vid_go     = vid_pend_q || vid_strobe;
    // The cycle after an ack the CPU may still be dropping its request.
    cpu_elig   = cpu_req && !ack_q && (vbl || !VBL_ONLY);
  end

  // Next-state logic and VRAM/CPU/video outputs
  always_comb begin
    state_d     = state_q;
    mem_ce      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 8'h00;
    cpu_ack     = 1'b0;
    vid_valid   = 1'b0;
    vid_data    = vid_data_q;
    cpu_rdata   = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (vid_go)        state_d = ST_VID;
        else if (cpu_elig) state_d = ST_CPU;
      end
      ST_VID: begin
        mem_ce   = 1'b1;
        mem_addr = vaddr_q;
        state_d  = ST_VID_CAP;
      end
      ST_VID_CAP: begin
        // Read data is forwarded in the pulse cycle and held afterwards.
        vid_valid  = rst;
        vid_data   = rst ? mem_rdata : vid_data_q;
        vid_data_d = mem_rdata;
        // Arbitrate directly so a waiting CPU is not delayed by an IDLE cycle.
        if (vid_go)        state_d = ST_VID;
        else if (cpu_elig) state_d = ST_CPU;
        else               state_d = ST_IDLE;
      end
      ST_CPU: begin
        mem_ce    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        state_d   = ST_CPU_CAP;
      end
      ST_CPU_CAP: begin
        cpu_ack = rst;
        if (!cpu_we) begin
          cpu_rdata   = rst ? mem_rdata : cpu_rdata_q;
          cpu_rdata_d = mem_rdata;
        end
        state_d = vid_go ? ST_VID : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    vid_pend_d = vid_go && (state_d != ST_VID);
    vaddr_d    = vid_strobe ? vaddr_calc : vaddr_q;
    ack_d      = cpu_ack;
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      vid_pend_q  <= 1'b0;
      vaddr_q     <= 16'h0000;
      vid_data_q  <= 8'h00;
      cpu_rdata_q <= 8'h00;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vid_pend_q  <= vid_pend_d;
      vaddr_q     <= vaddr_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      ack_q       <= ack_d;
    end
  end

endmodule

// File: tb/tb_tv_vram_arbiter.sv
// Directed bench for tv_vram_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later, well clear of the next edge.
module tb_tv_vram_arbiter;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        pixel_clk;
  logic [8:0]  cntHS;
  logic [8:0]  cntVS;
  logic        vbl;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ce;
  logic [7:0]  mem_rdata;
  logic [7:0]  vid_data;
  logic        vid_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  tv_vram_arbiter dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .pixel_clk (pixel_clk),
    .cntHS     (cntHS),
    .cntVS     (cntVS),
    .vbl       (vbl),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ce    (mem_ce),
    .mem_rdata (mem_rdata),
    .vid_data  (vid_data),
    .vid_valid (vid_valid)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic strobe(input logic [8:0] vs, input logic [8:0] hs);
    cntVS = vs;
    cntHS = hs;
    pixel_clk = 1'b1;
  endtask

  initial begin : stim
    logic seen;
    rst = 1'b0; pixel_clk = 1'b0; cntHS = '0; cntVS = '0; vbl = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
    cyc(); cyc(); settle();
    chk("rst_mem_ce", 16'(mem_ce), 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_cpu_ack", 16'(cpu_ack), 16'd0);
    chk("rst_vid_valid", 16'(vid_valid), 16'd0);
    chk("rst_vid_data", 16'(vid_data), 16'd0);
    chk("rst_cpu_rdata", 16'(cpu_rdata), 16'd0);

    // first video fetch of the frame
    cyc(); rst = 1'b1;
    cyc(); strobe(9'd56, 9'd88); settle();
    chk("v1_idle_ce", 16'(mem_ce), 16'd0);
    cyc(); pixel_clk = 1'b0; mem_rdata = 8'hA5; settle();
    chk("v1_ce", 16'(mem_ce), 16'd1);
    chk("v1_we", 16'(mem_we), 16'd0);
    chk("v1_addr", mem_addr, 16'h4000);
    cyc(); settle();
    chk("v1_valid", 16'(vid_valid), 16'd1);
    chk("v1_data", 16'(vid_data), 16'h00A5);
    cyc(); mem_rdata = 8'h00; settle();
    chk("v1_valid_off", 16'(vid_valid), 16'd0);
    chk("v1_data_hold", 16'(vid_data), 16'h00A5);

    // second line, second column
    cyc(); strobe(9'd57, 9'd96);
    cyc(); pixel_clk = 1'b0; mem_rdata = 8'h3C; settle();
    chk("v2_addr", mem_addr, 16'h4021);
    cyc(); settle();
    chk("v2_data", 16'(vid_data), 16'h003C);

    // last fetch of the active area
    cyc(); strobe(9'd247, 9'd336);
    cyc(); pixel_clk = 1'b0; settle();
    chk("v_last_addr", mem_addr, 16'h57FF);
    cyc(); cyc();

    // strobes outside the window must not fetch
    strobe(9'd56, 9'd80);
    cyc(); pixel_clk = 1'b0; settle();
    chk("v_left_edge", 16'(mem_ce), 16'd0);
    strobe(9'd56, 9'd344);
    cyc(); pixel_clk = 1'b0; settle();
    chk("v_right_edge", 16'(mem_ce), 16'd0);
    strobe(9'd248, 9'd88);
    cyc(); pixel_clk = 1'b0; settle();
    chk("v_bottom_edge", 16'(mem_ce), 16'd0);
    strobe(9'd56, 9'd89);
    cyc(); pixel_clk = 1'b0; settle();
    chk("v_odd_hs", 16'(mem_ce), 16'd0);

    // CPU write, request held one cycle past ack
    vbl = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
    cyc(); settle();
    chk("w_ce", 16'(mem_ce), 16'd1);
    chk("w_we", 16'(mem_we), 16'd1);
    chk("w_addr", mem_addr, 16'h1234);
    chk("w_wdata", 16'(mem_wdata), 16'h005A);
    chk("w_ack_early", 16'(cpu_ack), 16'd0);
    cyc(); settle();
    chk("w_ack", 16'(cpu_ack), 16'd1);
    chk("w_ce_off", 16'(mem_ce), 16'd0);
    cyc(); settle();
    chk("w_ack_pulse", 16'(cpu_ack), 16'd0);
    cyc(); cpu_req = 1'b0; settle();
    chk("w_inelig", 16'(mem_ce), 16'd0);

    // CPU read
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00FF;
    cyc(); settle();
    chk("r_we", 16'(mem_we), 16'd0);
    chk("r_addr", mem_addr, 16'h00FF);
    mem_rdata = 8'hC3;
    cyc(); settle();
    chk("r_ack", 16'(cpu_ack), 16'd1);
    chk("r_rdata", 16'(cpu_rdata), 16'h00C3);
    cyc(); cpu_req = 1'b0; mem_rdata = 8'h00; settle();
    chk("r_rdata_hold", 16'(cpu_rdata), 16'h00C3);

    // simultaneous video strobe and CPU request: video first
    cyc(); strobe(9'd60, 9'd88); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    cyc(); pixel_clk = 1'b0; mem_rdata = 8'h77; settle();
    chk("s_vid_addr", mem_addr, 16'h4080);
    chk("s_vid_ce", 16'(mem_ce), 16'd1);
    cyc(); settle();
    chk("s_vid_valid", 16'(vid_valid), 16'd1);
    chk("s_vid_data", 16'(vid_data), 16'h0077);
    chk("s_no_ack", 16'(cpu_ack), 16'd0);
    cyc(); settle();
    chk("s_cpu_ce", 16'(mem_ce), 16'd1);
    chk("s_cpu_addr", mem_addr, 16'h2000);
    mem_rdata = 8'h11;
    cyc(); settle();
    chk("s_cpu_ack", 16'(cpu_ack), 16'd1);
    chk("s_cpu_rdata", 16'(cpu_rdata), 16'h0011);
    cyc(); cpu_req = 1'b0; mem_rdata = 8'h00;

    // video strobe during a CPU access is deferred, not lost
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h99;
    cyc(); strobe(9'd56, 9'd96); settle();
    chk("p_cpu_ce", mem_addr, 16'h3000);
    cyc(); pixel_clk = 1'b0; settle();
    chk("p_ack", 16'(cpu_ack), 16'd1);
    cyc(); cpu_req = 1'b0; settle();
    chk("p_vid_ce", 16'(mem_ce), 16'd1);
    chk("p_vid_addr", mem_addr, 16'h4001);
    cyc(); cyc();

    // CPU access with vbl low
    vbl = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(); settle();
      if (cpu_ack) seen = 1'b1;
    end
`ifdef VRAM_VBL_ONLY_EN
    chk("vbl_blocked", 16'(seen), 16'd0);
`else
    chk("vbl_any_time", 16'(seen), 16'd1);
`endif
    cpu_req = 1'b0;
    cyc(); cyc();
    cpu_req = 1'b1; vbl = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(); settle();
      if (cpu_ack && !seen) begin
        seen = 1'b1;
        cpu_req = 1'b0;
      end
    end
    chk("vbl_served", 16'(seen), 16'd1);

    // reset in CPU state aborts the access
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 8'h22;
    cyc(); settle();
    chk("x_cpu_ce", 16'(mem_ce), 16'd1);
    rst = 1'b0;
    cyc(); settle();
    chk("x_no_ack", 16'(cpu_ack), 16'd0);
    chk("x_ce", 16'(mem_ce), 16'd0);
    chk("x_we", 16'(mem_we), 16'd0);
    chk("x_addr", mem_addr, 16'h0000);
    chk("x_vid_data", 16'(vid_data), 16'h0000);
    chk("x_cpu_rdata", 16'(cpu_rdata), 16'h0000);
    chk("x_vid_valid", 16'(vid_valid), 16'd0);

    // reset landing in CPU_CAP suppresses the ack
    rst = 1'b1;
    cyc(); cyc(); rst = 1'b0; settle();
    chk("x_cap_no_ack", 16'(cpu_ack), 16'd0);
    cpu_req = 1'b0;
    cyc(); settle();
    chk("x_cap_after", 16'(cpu_ack), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
